// File: rtl/ir_code_player.sv
// ir_code_player
// Plays back an IR remote-control code stored as a table of
// {last, mark, space} entries. Each mark is driven as a modulated carrier
// on the enabled LEDs, and each space leaves the LEDs idle. Durations are
// counted in carrier periods.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start, stop    level start (sampled in IDLE) / synchronous abort
//   loop_forever   restart from entry 0 after the last entry while high
//   carrier_div    carrier half-period in clk cycles (latched at start)
//   led_mask       per-LED enable (latched at start)
//   rom_addr       code-table read address
//   rom_data       {last, mark, space}, valid one cycle after rom_addr
//   busy           high whenever not IDLE
//   done           one-cycle pulse after normal completion
//   fail           sticky error flag, cleared by the next accepted start
//   ir_out         modulated LED drive (active-low when INVERT=1)
module ir_code_player #(
   parameter int DIV_W  = 12,
   parameter int DUR_W  = 16,
   parameter int ADDR_W = 8,
   parameter int LEDS   = 2,
   parameter int INVERT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 loop_forever,
   input  logic [DIV_W-1:0]     carrier_div,
   input  logic [LEDS-1:0]      led_mask,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [2*DUR_W:0]     rom_data,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [LEDS-1:0]      ir_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_MARK  = 3'd3;
   localparam logic [2:0] S_SPACE = 3'd4;

   localparam logic [DIV_W-1:0] DIV_ONE  = 1;
   localparam logic [DUR_W:0]   HALF_ONE = 1;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DIV_W-1:0]  div_q,   div_d;
   logic [LEDS-1:0]   mask_q,  mask_d;
   logic [DIV_W-1:0]  cnt_q,   cnt_d;    // clk cycles within a carrier half
   logic [DUR_W:0]    half_q,  half_d;   // carrier halves left after this one
   logic              phase_q, phase_d;
   logic [DUR_W-1:0]  space_q, space_d;
   logic              last_q,  last_d;
   logic              done_q,  done_d;
   logic              fail_q,  fail_d;

   logic              rd_last;
   logic [DUR_W-1:0]  rd_mark;
   logic [DUR_W-1:0]  rd_space;
   logic              half_end;
   logic              mark_end;
   logic              entry_end;

   assign rd_last  = rom_data[2*DUR_W];
   assign rd_mark  = rom_data[2*DUR_W-1:DUR_W];
   assign rd_space = rom_data[DUR_W-1:0];

   // div_q is never zero while busy, so div_q-1 cannot underflow there.
   // The half counter (DUR_W+1 bits) combined with the cycle counter
   // (DIV_W bits) spans 2*div*dur cycles without overflow.
   assign half_end = (cnt_q == (div_q - DIV_ONE));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      div_d     = div_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      phase_d   = phase_q;
      space_d   = space_q;
      last_d    = last_q;
      done_d    = 1'b0;
      fail_d    = fail_q;
      mark_end  = 1'b0;
      entry_end = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               if (carrier_div != '0) begin
                  state_d = S_FETCH;
                  addr_d  = '0;
                  fail_d  = 1'b0;
                  div_d   = carrier_div;
                  mask_d  = led_mask;
               end else begin
                  fail_d  = 1'b1;
               end
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            if (rd_mark == '0) begin
               fail_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_MARK;
               cnt_d   = '0;
               phase_d = 1'b1;
               half_d  = {rd_mark, 1'b0} - HALF_ONE;
               space_d = rd_space;
               last_d  = rd_last;
            end
         end
         S_MARK, S_SPACE: begin
            if (half_end) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
               if (half_q == '0) begin
                  if (state_q == S_MARK) mark_end  = 1'b1;
                  else                   entry_end = 1'b1;
               end else begin
                  half_d = half_q - HALF_ONE;
               end
            end else begin
               cnt_d = cnt_q + DIV_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A zero space skips SPACE entirely, so the entry ends with the mark.
      if (mark_end) begin
         if (space_q != '0) begin
            state_d = S_SPACE;
            cnt_d   = '0;
            half_d  = {space_q, 1'b0} - HALF_ONE;
         end else begin
            entry_end = 1'b1;
         end
      end

      if (entry_end) begin
         if (last_q) begin
            if (loop_forever) begin
               addr_d  = '0;
               state_d = S_FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end else if (&addr_q) begin
            // Running off the end of the table is an error, not a wrap.
            fail_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
         end
      end

      // Abort wins over everything else; fail keeps its previous value.
      if (stop && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         fail_d  = fail_q;
         cnt_d   = '0;
         half_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         div_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         half_q  <= '0;
         phase_q <= 1'b0;
         space_q <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         div_q   <= div_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         phase_q <= phase_d;
         space_q <= space_d;
         last_q  <= last_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   assign rom_addr = addr_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign fail     = fail_q;

   // Decoded straight from reset-cleared state so reset idles the LEDs
   // without waiting for a clock edge.
   assign ir_out = ({LEDS{(state_q == S_MARK) && phase_q}} & mask_q)
                   ^ {LEDS{INVERT != 0}};

endmodule
